// File: rtl/oflow_core_read_sequencer_if.sv
// oflow_core_read_sequencer_if
//
// Groups the frame-control, buffer-read handshake and line-request signals
// that connect the read sequencer to the rest of the oflow core.
//
// Signals:
//   start_frame      1-cycle frame start request (into sequencer)
//   abort            synchronous frame abort (into sequencer)
//   num_of_sets      number of sets in the frame (into sequencer)
//   remain_bboxes    bboxes in the last set (into sequencer)
//   done_read        buffer-read FSM finished the set read (into sequencer)
//   done_score_calc  score calculation for the set finished (into sequencer)
//   line_req         per-PE new-line request levels (into sequencer)
//   start_read       kick to the buffer-read FSM (from sequencer)
//   read_new_line    single-cycle line-advance pulse (from sequencer)
//   line_count       line pulses issued in the current set (from sequencer)
//   cur_set          index of the set in progress (from sequencer)
//   busy             sequencer is not idle (from sequencer)
//   frame_done       frame finished (from sequencer)
//   err_start_busy   start_frame arrived while busy (from sequencer)
//
// Modports: master drives the requests, slave is the sequencer itself.

interface oflow_core_read_sequencer_if #(
    parameter int PE_NUM     = 24,
    parameter int SET_LEN    = 4,
    parameter int REMAIN_LEN = 5,
    parameter int LINE_LEN   = 8
);

    logic                  start_frame;
    logic                  abort;
    logic [SET_LEN-1:0]    num_of_sets;
    logic [REMAIN_LEN-1:0] remain_bboxes;
    logic                  done_read;
    logic                  done_score_calc;
    logic [PE_NUM-1:0]     line_req;

    logic                  start_read;
    logic                  read_new_line;
    logic [LINE_LEN-1:0]   line_count;
    logic [SET_LEN-1:0]    cur_set;
    logic                  busy;
    logic                  frame_done;
    logic                  err_start_busy;

    modport master (
        output start_frame, abort, num_of_sets, remain_bboxes,
               done_read, done_score_calc, line_req,
        input  start_read, read_new_line, line_count, cur_set,
               busy, frame_done, err_start_busy
    );

    modport slave (
        input  start_frame, abort, num_of_sets, remain_bboxes,
               done_read, done_score_calc, line_req,
        output start_read, read_new_line, line_count, cur_set,
               busy, frame_done, err_start_busy
    );

endinterface

// File: rtl/oflow_core_read_sequencer.sv
// oflow_core_read_sequencer
//
// Read-control FSM for the oflow core. For each frame it walks through the
// configured number of sets; for every set it kicks the buffer-read FSM,
// waits for the read to finish, emits one line-advance pulse each time all
// active PEs ask for a new line, and waits for score completion before
// moving on. The last set may be partial, so only the low remain_bboxes PEs
// are considered there.
//
// Ports:
//   clk      clock
//   reset_N  asynchronous active-low reset
//   bus      slave side of oflow_core_read_sequencer_if (all handshakes)

module oflow_core_read_sequencer #(
    parameter int PE_NUM     = 24,
    parameter int SET_LEN    = 4,
    parameter int REMAIN_LEN = 5,
    parameter int LINE_LEN   = 8
) (
    input  logic                           clk,
    input  logic                           reset_N,
    oflow_core_read_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        READ,
        WAIT_SCORE,
        DONE
    } state_t;

    state_t                state_q;
    logic [SET_LEN-1:0]    sets_q;
    logic [REMAIN_LEN-1:0] remain_q;
    logic [SET_LEN-1:0]    cur_set_q;
    logic [LINE_LEN-1:0]   line_count_q;
    logic [LINE_LEN-1:0]   line_count_d;
    logic                  score_flag_q;
    logic                  match_prev_q;
    logic                  read_new_line_q;
    logic                  err_start_busy_q;

    logic                  last_set;
    logic [REMAIN_LEN-1:0] active_cnt;
    logic [PE_NUM-1:0]     mask;
    logic                  match;
    logic                  line_pulse;

    // The last set is the one whose index equals the latched count minus one.
    assign last_set = (cur_set_q == (sets_q - SET_LEN'(1)));

    // A remaining count of zero, or one larger than the PE array, means the
    // whole array is active on the last set.
    always_comb begin
        active_cnt = remain_q;
        if ((remain_q == '0) || (remain_q > REMAIN_LEN'(PE_NUM))) begin
            active_cnt = REMAIN_LEN'(PE_NUM);
        end
    end

    // On the last set only the low active_cnt PEs take part; all other sets
    // use every PE.
    always_comb begin
        mask = '1;
        for (int i = 0; i < PE_NUM; i++) begin
            mask[i] = !last_set || (i < int'(active_cnt));
        end
    end

    // Requests outside the mask are ignored; the match is only meaningful
    // while a set is being read. Rising-edge qualification turns a held
    // request into a single line pulse.
    assign match        = (state_q == READ) && ((bus.line_req & mask) == mask);
    assign line_pulse   = match && !match_prev_q;
    assign line_count_d = (line_count_q == '1) ? line_count_q
                                               : line_count_q + LINE_LEN'(1);

    // Single sequencing process: state, latched configuration, set and line
    // counters, the sticky early-score flag and the registered pulses.
    // Abort overrides every state transition, and start_frame outside IDLE
    // only raises the error pulse.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q          <= IDLE;
            sets_q           <= '0;
            remain_q         <= '0;
            cur_set_q        <= '0;
            line_count_q     <= '0;
            score_flag_q     <= 1'b0;
            match_prev_q     <= 1'b0;
            read_new_line_q  <= 1'b0;
            err_start_busy_q <= 1'b0;
        end else begin
            read_new_line_q  <= 1'b0;
            match_prev_q     <= 1'b0;
            err_start_busy_q <= bus.start_frame && (state_q != IDLE);

            if (bus.abort) begin
                state_q      <= IDLE;
                cur_set_q    <= '0;
                line_count_q <= '0;
                score_flag_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_frame) begin
                            sets_q    <= bus.num_of_sets;
                            remain_q  <= bus.remain_bboxes;
                            cur_set_q <= '0;
                            state_q   <= (bus.num_of_sets == '0) ? DONE : ISSUE;
                        end
                    end

                    ISSUE: begin
                        line_count_q <= '0;
                        score_flag_q <= 1'b0;
                        state_q      <= READ;
                    end

                    READ: begin
                        match_prev_q    <= match;
                        read_new_line_q <= line_pulse;
                        if (line_pulse) begin
                            line_count_q <= line_count_d;
                        end
                        // Scores may finish before the read does; remember it
                        // so WAIT_SCORE can leave immediately.
                        if (bus.done_score_calc) begin
                            score_flag_q <= 1'b1;
                        end
                        if (bus.done_read) begin
                            state_q <= WAIT_SCORE;
                        end
                    end

                    WAIT_SCORE: begin
                        if (bus.done_score_calc || score_flag_q) begin
                            if (last_set) begin
                                state_q <= DONE;
                            end else begin
                                cur_set_q <= cur_set_q + SET_LEN'(1);
                                state_q   <= ISSUE;
                            end
                        end
                    end

                    DONE: begin
                        state_q <= IDLE;
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.start_read     = (state_q == ISSUE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.frame_done     = (state_q == DONE);
    assign bus.read_new_line  = read_new_line_q;
    assign bus.line_count     = line_count_q;
    assign bus.cur_set        = cur_set_q;
    assign bus.err_start_busy = err_start_busy_q;

endmodule

// File: tb/tb_oflow_core_read_sequencer.sv
// tb_oflow_core_read_sequencer
//
// Self-checking bench for oflow_core_read_sequencer. Each scenario task
// drives the interface and checks the responses inline. Every start_read is
// matched against a queue of expected set indices filled as frames are
// launched.

module tb_oflow_core_read_sequencer;

    localparam int PE_NUM     = 24;
    localparam int SET_LEN    = 4;
    localparam int REMAIN_LEN = 5;
    localparam int LINE_LEN   = 8;

    logic clk;
    logic reset_N;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [SET_LEN-1:0] expSet[$];
    logic [SET_LEN-1:0] expectedSet;

    oflow_core_read_sequencer_if #(
        .PE_NUM(PE_NUM), .SET_LEN(SET_LEN),
        .REMAIN_LEN(REMAIN_LEN), .LINE_LEN(LINE_LEN)
    ) bus ();

    oflow_core_read_sequencer #(
        .PE_NUM(PE_NUM), .SET_LEN(SET_LEN),
        .REMAIN_LEN(REMAIN_LEN), .LINE_LEN(LINE_LEN)
    ) dut (
        .clk(clk),
        .reset_N(reset_N),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every start_read must correspond to a queued set index.
    always @(negedge clk) begin
        if (reset_N && bus.start_read) begin
            testsRun++;
            if (expSet.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_start_read: cur_set=%0d, no issue expected", bus.cur_set);
            end else begin
                expectedSet = expSet.pop_front();
                if (bus.cur_set !== expectedSet) begin
                    testsFailed++;
                    $display("[TB] FAIL issue_cur_set: got %0d, expected %0d", bus.cur_set, expectedSet);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start_frame     = 1'b0;
        bus.abort           = 1'b0;
        bus.num_of_sets     = '0;
        bus.remain_bboxes   = '0;
        bus.done_read       = 1'b0;
        bus.done_score_calc = 1'b0;
        bus.line_req        = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_N = 1'b1;
        #2 reset_N = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if ({bus.start_read, bus.read_new_line, bus.line_count, bus.cur_set,
             bus.busy, bus.frame_done, bus.err_start_busy} !== 17'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: busy=%b start_read=%b cur_set=%0d line_count=%0d, expected all 0",
                     bus.busy, bus.start_read, bus.cur_set, bus.line_count);
        end
        @(negedge clk) reset_N = 1'b1;
        tick();
        tick();
        testsRun++;
        if (bus.busy !== 1'b0 || bus.start_read !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_idle: busy=%b start_read=%b, expected 0 0", bus.busy, bus.start_read);
        end
    endtask

    task automatic test_basic_frame();
        expSet.push_back(4'd0);
        expSet.push_back(4'd1);
        expSet.push_back(4'd2);
        bus.num_of_sets   = 4'd3;
        bus.remain_bboxes = 5'd24;
        bus.start_frame   = 1'b1;
        tick();
        bus.start_frame   = 1'b0;
        testsRun++;
        if (bus.start_read !== 1'b1 || bus.busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL basic_first_issue: start_read=%b busy=%b, expected 1 1", bus.start_read, bus.busy);
        end
        for (int s = 0; s < 3; s++) begin
            tick();
            testsRun++;
            if (bus.start_read !== 1'b0 || bus.busy !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL basic_read_state: set %0d start_read=%b busy=%b, expected 0 1", s, bus.start_read, bus.busy);
            end
            bus.done_read = 1'b1;
            tick();
            bus.done_read = 1'b0;
            bus.done_score_calc = 1'b1;
            tick();
            bus.done_score_calc = 1'b0;
            if (s < 2) begin
                testsRun++;
                if (bus.start_read !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL basic_next_issue: set %0d start_read=%b, expected 1", s + 1, bus.start_read);
                end
            end
        end
        testsRun++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b1 || bus.cur_set !== 4'd2) begin
            testsFailed++;
            $display("[TB] FAIL basic_done: frame_done=%b busy=%b cur_set=%0d, expected 1 1 2",
                     bus.frame_done, bus.busy, bus.cur_set);
        end
        tick();
        testsRun++;
        if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.cur_set !== 4'd2) begin
            testsFailed++;
            $display("[TB] FAIL basic_idle: frame_done=%b busy=%b cur_set=%0d, expected 0 0 2",
                     bus.frame_done, bus.busy, bus.cur_set);
        end
    endtask

    task automatic test_mask();
        int pulses;
        expSet.push_back(4'd0);
        expSet.push_back(4'd1);
        bus.num_of_sets   = 4'd2;
        bus.remain_bboxes = 5'd5;
        bus.start_frame   = 1'b1;
        tick();
        bus.start_frame   = 1'b0;
        tick();
        bus.line_req = 24'h00001F;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin tick(); pulses += int'(bus.read_new_line); end
        testsRun++;
        if (pulses !== 0) begin
            testsFailed++;
            $display("[TB] FAIL mask_nonlast_partial: pulses=%0d, expected 0", pulses);
        end
        bus.line_req = 24'hFFFFFF;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin tick(); pulses += int'(bus.read_new_line); end
        testsRun++;
        if (pulses !== 1) begin
            testsFailed++;
            $display("[TB] FAIL mask_nonlast_full: pulses=%0d, expected 1", pulses);
        end
        bus.line_req  = '0;
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_score_calc = 1'b0;
        tick();
        bus.line_req = 24'h00000F;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin tick(); pulses += int'(bus.read_new_line); end
        testsRun++;
        if (pulses !== 0) begin
            testsFailed++;
            $display("[TB] FAIL mask_last_short: pulses=%0d, expected 0", pulses);
        end
        bus.line_req = 24'h00001F;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin tick(); pulses += int'(bus.read_new_line); end
        testsRun++;
        if (pulses !== 1 || bus.line_count !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL mask_last_exact: pulses=%0d line_count=%0d, expected 1 1", pulses, bus.line_count);
        end
        bus.line_req  = '0;
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_score_calc = 1'b0;
        testsRun++;
        if (bus.frame_done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL mask_frame_done: frame_done=%b, expected 1", bus.frame_done);
        end
        tick();
    endtask

    task automatic test_held_request();
        int pulses;
        expSet.push_back(4'd0);
        bus.num_of_sets   = 4'd1;
        bus.remain_bboxes = 5'd0;
        bus.start_frame   = 1'b1;
        tick();
        bus.start_frame   = 1'b0;
        tick();
        bus.line_req = 24'hFFFFFF;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin tick(); pulses += int'(bus.read_new_line); end
        testsRun++;
        if (pulses !== 1 || bus.line_count !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL held_single_pulse: pulses=%0d line_count=%0d, expected 1 1", pulses, bus.line_count);
        end
        bus.line_req = '0;
        tick();
        tick();
        bus.line_req = 24'hFFFFFF;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin tick(); pulses += int'(bus.read_new_line); end
        testsRun++;
        if (pulses !== 1 || bus.line_count !== 8'd2) begin
            testsFailed++;
            $display("[TB] FAIL held_reassert: pulses=%0d line_count=%0d, expected 1 2", pulses, bus.line_count);
        end
        bus.line_req  = '0;
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_score_calc = 1'b0;
        tick();
    endtask

    task automatic test_early_score();
        expSet.push_back(4'd0);
        expSet.push_back(4'd1);
        bus.num_of_sets   = 4'd2;
        bus.remain_bboxes = 5'd24;
        bus.start_frame   = 1'b1;
        tick();
        bus.start_frame   = 1'b0;
        tick();
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_score_calc = 1'b0;
        tick();
        tick();
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        testsRun++;
        if (bus.start_read !== 1'b0 || bus.busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL early_wait_cycle: start_read=%b busy=%b, expected 0 1", bus.start_read, bus.busy);
        end
        tick();
        testsRun++;
        if (bus.start_read !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL early_issue_latency: start_read=%b, expected 1", bus.start_read);
        end
        tick();
        bus.done_read       = 1'b1;
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_read       = 1'b0;
        bus.done_score_calc = 1'b0;
        tick();
        testsRun++;
        if (bus.frame_done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_done: frame_done=%b, expected 1", bus.frame_done);
        end
        tick();
    endtask

    task automatic test_zero_sets();
        bus.num_of_sets   = 4'd0;
        bus.remain_bboxes = 5'd3;
        bus.start_frame   = 1'b1;
        tick();
        bus.start_frame   = 1'b0;
        testsRun++;
        if (bus.frame_done !== 1'b1 || bus.start_read !== 1'b0 || bus.busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL zero_sets_done: frame_done=%b start_read=%b busy=%b, expected 1 0 1",
                     bus.frame_done, bus.start_read, bus.busy);
        end
        tick();
        testsRun++;
        if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL zero_sets_idle: frame_done=%b busy=%b, expected 0 0", bus.frame_done, bus.busy);
        end
    endtask

    task automatic test_err_busy();
        expSet.push_back(4'd0);
        bus.num_of_sets   = 4'd1;
        bus.remain_bboxes = 5'd24;
        bus.start_frame   = 1'b1;
        tick();
        bus.start_frame   = 1'b0;
        testsRun++;
        if (bus.err_start_busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_idle_start: err_start_busy=%b, expected 0", bus.err_start_busy);
        end
        tick();
        bus.start_frame = 1'b1;
        tick();
        bus.start_frame = 1'b0;
        testsRun++;
        if (bus.err_start_busy !== 1'b1 || bus.start_read !== 1'b0 || bus.busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL err_busy_pulse: err=%b start_read=%b busy=%b, expected 1 0 1",
                     bus.err_start_busy, bus.start_read, bus.busy);
        end
        tick();
        testsRun++;
        if (bus.err_start_busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_busy_single: err_start_busy=%b, expected 0", bus.err_start_busy);
        end
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_score_calc = 1'b0;
        testsRun++;
        if (bus.frame_done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL err_state_kept: frame_done=%b, expected 1", bus.frame_done);
        end
        tick();
    endtask

    task automatic test_abort();
        expSet.push_back(4'd0);
        expSet.push_back(4'd1);
        bus.num_of_sets   = 4'd3;
        bus.remain_bboxes = 5'd24;
        bus.start_frame   = 1'b1;
        tick();
        bus.start_frame   = 1'b0;
        tick();
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_score_calc = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.line_req = 24'hFFFFFF;
            tick();
            bus.line_req = '0;
            tick();
        end
        testsRun++;
        if (bus.line_count !== 8'd4 || bus.cur_set !== 4'd1) begin
            testsFailed++;
            $display("[TB] FAIL abort_pre_state: line_count=%0d cur_set=%0d, expected 4 1", bus.line_count, bus.cur_set);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        testsRun++;
        if (bus.busy !== 1'b0 || bus.cur_set !== 4'd0 || bus.line_count !== 8'd0 || bus.read_new_line !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_clear: busy=%b cur_set=%0d line_count=%0d rnl=%b, expected 0 0 0 0",
                     bus.busy, bus.cur_set, bus.line_count, bus.read_new_line);
        end
        bus.num_of_sets = 4'd1;
        bus.abort       = 1'b1;
        bus.start_frame = 1'b1;
        tick();
        bus.abort       = 1'b0;
        bus.start_frame = 1'b0;
        testsRun++;
        if (bus.busy !== 1'b0 || bus.err_start_busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_blocks_start: busy=%b err=%b, expected 0 0", bus.busy, bus.err_start_busy);
        end
        expSet.push_back(4'd0);
        bus.start_frame = 1'b1;
        tick();
        bus.start_frame = 1'b0;
        testsRun++;
        if (bus.start_read !== 1'b1 || bus.cur_set !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL abort_restart: start_read=%b cur_set=%0d, expected 1 0", bus.start_read, bus.cur_set);
        end
        tick();
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_score_calc = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        expSet.push_back(4'd0);
        expSet.push_back(4'd1);
        bus.num_of_sets   = 4'd2;
        bus.remain_bboxes = 5'd24;
        bus.start_frame   = 1'b1;
        tick();
        bus.start_frame   = 1'b0;
        tick();
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        bus.done_score_calc = 1'b1;
        tick();
        bus.done_score_calc = 1'b0;
        tick();
        bus.line_req = 24'hFFFFFF;
        tick();
        bus.line_req  = '0;
        bus.done_read = 1'b1;
        tick();
        bus.done_read = 1'b0;
        testsRun++;
        if (bus.busy !== 1'b1 || bus.cur_set !== 4'd1 || bus.line_count !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL async_pre_state: busy=%b cur_set=%0d line_count=%0d, expected 1 1 1",
                     bus.busy, bus.cur_set, bus.line_count);
        end
        #2 reset_N = 1'b0;
        #1;
        testsRun++;
        if ({bus.start_read, bus.read_new_line, bus.line_count, bus.cur_set,
             bus.busy, bus.frame_done, bus.err_start_busy} !== 17'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_outputs: busy=%b cur_set=%0d line_count=%0d, expected all 0",
                     bus.busy, bus.cur_set, bus.line_count);
        end
        @(negedge clk) reset_N = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_mask();
        test_held_request();
        test_early_score();
        test_zero_sets();
        test_err_busy();
        test_abort();
        test_async_reset();
        tick();
        testsRun++;
        if (expSet.size() !== 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d issues still expected, expected 0", expSet.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
